// File: rtl/voltmeter_pkg.sv
// Shared encodings and ASCII constants for the voltmeter UART command path.
package voltmeter_pkg;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_e;

   typedef enum logic [1:0] {
      P_IDLE,
      P_D1,
      P_D2,
      P_END
   } parse_state_e;

   localparam logic [7:0] ASCII_C  = 8'h43;
   localparam logic [7:0] ASCII_c  = 8'h63;
   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;
   localparam logic [7:0] ASCII_0  = 8'h30;

   localparam int unsigned N_CHAN_DEFAULT = 13;

   function automatic logic is_digit(input logic [7:0] b);
      return (b >= ASCII_0) && (b <= 8'h39);
   endfunction

   function automatic logic is_cmd_lead(input logic [7:0] b);
      return (b == ASCII_C) || (b == ASCII_c);
   endfunction

endpackage

// File: rtl/uart_channel_cmd_if.sv
// Serial input plus received-byte and decoded-channel outputs of the command receiver.
interface uart_channel_cmd_if #(
   parameter int unsigned DBIT = 8
);
   logic            rx;
   logic [DBIT-1:0] rx_byte;
   logic            rx_done;
   logic            frame_err;
   logic [3:0]      chan;
   logic            chan_valid;
   logic            cmd_err;

   modport master (
      output rx,
      input  rx_byte, rx_done, frame_err, chan, chan_valid, cmd_err
   );

   modport slave (
      input  rx,
      output rx_byte, rx_done, frame_err, chan, chan_valid, cmd_err
   );
endinterface

// File: rtl/uart_rx.sv
// 8N1 receiver: two-flop synchroniser, 16x oversample tick divider and framing FSM.
module uart_rx
   import voltmeter_pkg::*;
#(
   parameter int unsigned DBIT     = 8,
   parameter int unsigned SB_TICK  = 16,
   parameter int unsigned DVSR     = 326,
   parameter int unsigned DVSR_BIT = 9
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            rx,
   output logic [DBIT-1:0] rx_byte,
   output logic            rx_done,
   output logic            frame_err
);

   localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;

   logic                rx_meta_q;
   logic                rx_s_q;
   logic [DVSR_BIT-1:0] div_q;
   logic                tick;
   rx_state_e           state_q;
   logic [3:0]          s_q;
   logic [NW-1:0]       n_q;
   logic [DBIT-1:0]     b_q;

   // Synchroniser idles high so reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   assign tick = (div_q == DVSR_BIT'(DVSR - 1));

   always_ff @(posedge clk) begin
      if (rst)       div_q <= '0;
      else if (tick) div_q <= '0;
      else           div_q <= div_q + DVSR_BIT'(1);
   end

   // Start bit is confirmed mid-bit; data and stop are then sampled every 16 ticks.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RX_IDLE;
         s_q       <= '0;
         n_q       <= '0;
         b_q       <= '0;
         rx_byte   <= '0;
         rx_done   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_done   <= 1'b0;
         frame_err <= 1'b0;
         case (state_q)
            RX_IDLE: begin
               if (!rx_s_q) begin
                  state_q <= RX_START;
                  s_q     <= '0;
               end
            end
            RX_START: begin
               if (tick) begin
                  if (s_q == 4'd7) begin
                     if (rx_s_q) begin
                        state_q <= RX_IDLE;
                     end else begin
                        state_q <= RX_DATA;
                        s_q     <= '0;
                        n_q     <= '0;
                     end
                  end else begin
                     s_q <= s_q + 4'd1;
                  end
               end
            end
            RX_DATA: begin
               if (tick) begin
                  if (s_q == 4'd15) begin
                     s_q <= '0;
                     b_q <= {rx_s_q, b_q[DBIT-1:1]};
                     if (n_q == NW'(DBIT - 1)) state_q <= RX_STOP;
                     else                      n_q     <= n_q + NW'(1);
                  end else begin
                     s_q <= s_q + 4'd1;
                  end
               end
            end
            RX_STOP: begin
               if (tick) begin
                  if (s_q == 4'(SB_TICK - 1)) begin
                     state_q <= RX_IDLE;
                     if (rx_s_q) begin
                        rx_byte <= b_q;
                        rx_done <= 1'b1;
                     end else begin
                        frame_err <= 1'b1;
                     end
                  end else begin
                     s_q <= s_q + 4'd1;
                  end
               end
            end
            default: state_q <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_channel_cmd.sv
// UART receive path plus "C<d>[<d>]<CR>" command parser selecting a voltmeter channel.
module uart_channel_cmd
   import voltmeter_pkg::*;
#(
   parameter int unsigned DBIT     = 8,
   parameter int unsigned SB_TICK  = 16,
   parameter int unsigned DVSR     = 326,
   parameter int unsigned DVSR_BIT = 9,
   parameter int unsigned N_CHAN   = N_CHAN_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   uart_channel_cmd_if.slave bus
);

   parse_state_e pstate_q;
   logic [6:0]   acc_q;
   logic [3:0]   chan_q;
   logic         chan_valid_q;
   logic         cmd_err_q;

   logic [7:0]   byte_c;
   logic [3:0]   digit_c;
   logic         is_digit_c;
   logic         is_lead_c;
   logic         is_cr_c;
   logic         in_range_c;
   parse_state_e resync_c;

   uart_rx #(
      .DBIT     (DBIT),
      .SB_TICK  (SB_TICK),
      .DVSR     (DVSR),
      .DVSR_BIT (DVSR_BIT)
   ) u_rx (
      .clk       (clk),
      .rst       (rst),
      .rx        (bus.rx),
      .rx_byte   (bus.rx_byte),
      .rx_done   (bus.rx_done),
      .frame_err (bus.frame_err)
   );

   assign byte_c     = 8'(bus.rx_byte);
   assign digit_c    = 4'(byte_c - ASCII_0);
   assign is_digit_c = is_digit(byte_c);
   assign is_lead_c  = is_cmd_lead(byte_c);
   assign is_cr_c    = (byte_c == ASCII_CR);
   assign in_range_c = (acc_q < 7'(N_CHAN));
   // A stray 'C' inside a broken command starts a fresh one.
   assign resync_c   = is_lead_c ? P_D1 : P_IDLE;

   always_ff @(posedge clk) begin
      if (rst) begin
         pstate_q     <= P_IDLE;
         acc_q        <= '0;
         chan_q       <= '0;
         chan_valid_q <= 1'b0;
         cmd_err_q    <= 1'b0;
      end else begin
         chan_valid_q <= 1'b0;
         cmd_err_q    <= 1'b0;
         if (bus.rx_done && (byte_c != ASCII_LF)) begin
            if (is_cr_c && ((pstate_q == P_D2) || (pstate_q == P_END))) begin
               pstate_q <= P_IDLE;
               if (in_range_c) begin
                  chan_q       <= acc_q[3:0];
                  chan_valid_q <= 1'b1;
               end else begin
                  cmd_err_q <= 1'b1;
               end
            end else begin
               case (pstate_q)
                  P_IDLE: begin
                     if (is_lead_c) pstate_q <= P_D1;
                  end
                  P_D1: begin
                     if (is_digit_c) begin
                        acc_q    <= 7'(digit_c);
                        pstate_q <= P_D2;
                     end else begin
                        cmd_err_q <= 1'b1;
                        pstate_q  <= resync_c;
                     end
                  end
                  P_D2: begin
                     if (is_digit_c) begin
                        acc_q    <= (acc_q * 7'd10) + 7'(digit_c);
                        pstate_q <= P_END;
                     end else begin
                        cmd_err_q <= 1'b1;
                        pstate_q  <= resync_c;
                     end
                  end
                  P_END: begin
                     cmd_err_q <= 1'b1;
                     pstate_q  <= resync_c;
                  end
                  default: pstate_q <= P_IDLE;
               endcase
            end
         end
      end
   end

   assign bus.chan       = chan_q;
   assign bus.chan_valid = chan_valid_q;
   assign bus.cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_uart_channel_cmd.sv
// Randomised serial-command bench for uart_channel_cmd with a string-level reference parser.
module tb_uart_channel_cmd;

   localparam int unsigned DVSR     = 4;
   localparam int unsigned DVSR_BIT = 3;
   localparam int unsigned BIT_CYC  = 16 * DVSR;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   uart_channel_cmd_if #(.DBIT(8)) bus ();

   uart_channel_cmd #(
      .DBIT     (8),
      .SB_TICK  (16),
      .DVSR     (DVSR),
      .DVSR_BIT (DVSR_BIT),
      .N_CHAN   (13)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec = 0;
   int n_mis = 0;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs != exp) begin
         n_mis++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Observed side: everything the DUT reports, in order.
   logic [7:0] obs_bytes[$];
   int         obs_evt[$];
   int         obs_ferr   = 0;
   int         pulse_viol = 0;
   logic       prev_done  = 1'b0;
   logic       prev_fe    = 1'b0;
   logic       prev_cv    = 1'b0;
   logic       prev_ce    = 1'b0;
   logic [3:0] prev_chan  = 4'd0;

   always @(negedge clk) begin
      if (rst) begin
         prev_done = 1'b0;
         prev_fe   = 1'b0;
         prev_cv   = 1'b0;
         prev_ce   = 1'b0;
         prev_chan = bus.chan;
      end else begin
         if (bus.rx_done)   obs_bytes.push_back(bus.rx_byte);
         if (bus.frame_err) obs_ferr++;
         if (bus.chan_valid) obs_evt.push_back(int'(bus.chan));
         if (bus.cmd_err)    obs_evt.push_back(-1);
         if ((bus.chan_valid || bus.cmd_err) && !prev_done) pulse_viol++;
         if (bus.chan_valid && bus.cmd_err) pulse_viol++;
         if ((bus.rx_done && prev_done) || (bus.frame_err && prev_fe)) pulse_viol++;
         if ((bus.chan_valid && prev_cv) || (bus.cmd_err && prev_ce)) pulse_viol++;
         if ((bus.chan != prev_chan) && !bus.chan_valid) pulse_viol++;
         prev_done = bus.rx_done;
         prev_fe   = bus.frame_err;
         prev_cv   = bus.chan_valid;
         prev_ce   = bus.cmd_err;
         prev_chan = bus.chan;
      end
   end

   // Reference: buffer the text of the command in flight and judge it as a whole.
   logic [7:0] mbuf[$];
   logic [7:0] exp_bytes[$];
   int         exp_evt[$];
   int         exp_chan = 0;
   int         exp_last = 0;
   int         exp_ferr = 0;

   function automatic bit is_lead(input logic [7:0] b);
      return (b == 8'h43) || (b == 8'h63);
   endfunction

   task automatic model_byte(input logic [7:0] b);
      int val;
      exp_bytes.push_back(b);
      exp_last = int'(b);
      if (b == 8'h0A) return;
      if (mbuf.size() == 0) begin
         if (is_lead(b)) mbuf.push_back(b);
      end else if (b == 8'h0D) begin
         if (mbuf.size() == 1) begin
            exp_evt.push_back(-1);
         end else begin
            val = 0;
            for (int i = 1; i < mbuf.size(); i++) val = val * 10 + int'(mbuf[i] - 8'h30);
            if (val < 13) begin
               exp_evt.push_back(val);
               exp_chan = val;
            end else begin
               exp_evt.push_back(-1);
            end
         end
         mbuf.delete();
      end else if (b >= 8'h30 && b <= 8'h39 && mbuf.size() < 3) begin
         mbuf.push_back(b);
      end else begin
         exp_evt.push_back(-1);
         mbuf.delete();
         if (is_lead(b)) mbuf.push_back(b);
      end
   endtask

   // Drive one 8N1 frame; abort_at>0 stops driving after that many bit periods.
   task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int abort_at);
      logic [9:0] f;
      f = {stop_ok, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         if (abort_at > 0 && i == abort_at) begin
            bus.rx = 1'b1;
            return;
         end
         bus.rx = f[i];
         if (i == 9 && !stop_ok) begin
            repeat (BIT_CYC * 12 / 16) @(posedge clk);
            bus.rx = 1'b1;
            repeat (BIT_CYC) @(posedge clk);
         end else begin
            repeat (BIT_CYC) @(posedge clk);
         end
      end
      bus.rx = 1'b1;
   endtask

   task automatic send_good(input logic [7:0] b);
      send_frame(b, 1'b1, 0);
      model_byte(b);
   endtask

   task automatic send_cmd(input string s);
      for (int i = 0; i < s.len(); i++) send_good(s[i]);
      send_good(8'h0D);
   endtask

   task automatic checkpoint(input string tag);
      repeat (2 * BIT_CYC) @(posedge clk);
      #1;
      check_eq({tag, "/nbytes"}, obs_bytes.size(), exp_bytes.size());
      for (int i = 0; i < exp_bytes.size() && i < obs_bytes.size(); i++)
         check_eq($sformatf("%s/byte%0d", tag, i), int'(obs_bytes[i]), int'(exp_bytes[i]));
      check_eq({tag, "/nevt"}, obs_evt.size(), exp_evt.size());
      for (int i = 0; i < exp_evt.size() && i < obs_evt.size(); i++)
         check_eq($sformatf("%s/evt%0d", tag, i), obs_evt[i], exp_evt[i]);
      check_eq({tag, "/chan"}, int'(bus.chan), exp_chan);
      check_eq({tag, "/rx_byte"}, int'(bus.rx_byte), exp_last);
      check_eq({tag, "/frame_err"}, obs_ferr, exp_ferr);
      obs_bytes.delete();
      exp_bytes.delete();
      obs_evt.delete();
      exp_evt.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "/rx_byte"},    int'(bus.rx_byte),    0);
      check_eq({tag, "/rx_done"},    int'(bus.rx_done),    0);
      check_eq({tag, "/frame_err"},  int'(bus.frame_err),  0);
      check_eq({tag, "/chan"},       int'(bus.chan),       0);
      check_eq({tag, "/chan_valid"}, int'(bus.chan_valid), 0);
      check_eq({tag, "/cmd_err"},    int'(bus.cmd_err),    0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      logic [7:0] rq[$];
      int         kind;
      int         v;

      rst    = 1'b1;
      bus.rx = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check_reset_outputs("por");
      rst = 1'b0;

      send_cmd("C7");
      checkpoint("c7");

      send_cmd("c12");
      send_cmd("C13");
      checkpoint("c12_c13");

      send_cmd("CX");
      send_cmd("CC5");
      send_good(8'h0A);
      checkpoint("resync");

      send_frame(8'h55, 1'b0, 0);
      exp_ferr++;
      checkpoint("frame_err");

      // Short low pulse on idle line must be rejected as a glitch.
      bus.rx = 1'b0;
      repeat (2 * DVSR) @(posedge clk);
      bus.rx = 1'b1;
      checkpoint("glitch");
      send_cmd("C3");
      checkpoint("c3");

      send_good(8'h43);
      send_frame(8'h39, 1'b1, 5);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_reset_outputs("midrst");
      @(posedge clk);
      rst = 1'b0;
      mbuf.delete();
      exp_chan = 0;
      exp_last = 0;
      checkpoint("after_rst");
      send_cmd("C2");
      checkpoint("c2");

      for (int it = 0; it < 8; it++) begin
         rq.delete();
         kind = int'($urandom_range(0, 3));
         case (kind)
            0: begin
               rq.push_back(($urandom_range(0, 1) != 0) ? 8'h43 : 8'h63);
               rq.push_back(8'(8'h30 + $urandom_range(0, 9)));
               rq.push_back(8'h0D);
            end
            1: begin
               v = int'($urandom_range(0, 99));
               rq.push_back(8'h43);
               rq.push_back(8'(8'h30 + v / 10));
               rq.push_back(8'(8'h30 + v % 10));
               rq.push_back(8'h0D);
            end
            2: begin
               for (int k = 0; k < int'($urandom_range(1, 3)); k++) rq.push_back(8'($urandom));
               rq.push_back(8'h0D);
            end
            default: begin
               rq.push_back(8'h63);
               rq.push_back(8'($urandom));
               rq.push_back(8'h0D);
            end
         endcase
         if ($urandom_range(0, 1) != 0) rq.push_back(8'h0A);
         foreach (rq[k]) send_good(rq[k]);
         checkpoint($sformatf("rand%0d", it));
      end

      check_eq("pulse_rules", pulse_viol, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
